// File: rtl/ser_tx_pkg.sv
// Shared types and helpers for the falling-edge serial transmitter.
package ser_tx_pkg;

  // Frame phases of the transmitter FSM.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clock cycles occupied by one complete frame.
  function automatic int frame_cycles(input int data_w, input int div,
                                      input int parity_en, input int stop_bits);
    return (1 + data_w + parity_en + stop_bits) * div;
  endfunction

endpackage

// File: rtl/ser_tx_baud.sv
// Bit-period divider: counts 0..DIV-1 on the falling edge and flags the last
// count. With DIV=1 the counter never leaves 0, so the tick is always high.
module ser_tx_baud
  import ser_tx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(DIV);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  assign tick = (r_cnt == CW'(DIV - 1));

  // Restart on clear (frame accept) or wrap after the last count.
  always_comb begin
    w_cnt_next = r_cnt + 1'b1;
    if (clr || tick) begin
      w_cnt_next = '0;
    end
  end

  // Divider register, falling edge with asynchronous clear.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/ser_tx_negedge.sv
// Framed serial transmitter (start, LSB-first data, optional even parity,
// stop bits). All state lives in falling-edge flops with asynchronous
// set/clear, so the idle-high line is a pure preset.
module ser_tx_negedge
  import ser_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy
);

  localparam int BW = cnt_width(DATA_W);

  tx_state_t         r_state, w_state_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic [DATA_W-1:0] w_shift_rsh;
  logic [BW-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic              r_stop_cnt, w_stop_cnt_next;
  logic              r_parity, w_parity_next;
  logic              r_tx, w_tx_next;
  logic              r_ready, w_ready_next;
  logic              r_busy, w_busy_next;
  logic              w_accept;
  logic              w_tick;

  // Ready is only ever high in IDLE, so this is the whole accept condition.
  assign w_accept    = valid_in && r_ready;
  assign w_shift_rsh = r_shift >> 1;

  assign ready_out = r_ready;
  assign tx_out    = r_tx;
  assign busy      = r_busy;

  ser_tx_baud #(
    .DIV(DIV)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (w_accept),
    .tick (w_tick)
  );

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_parity_next   = r_parity;
    w_tx_next       = r_tx;
    w_ready_next    = r_ready;
    w_busy_next     = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next  = ST_START;
          w_shift_next  = data_in;
          w_parity_next = ^data_in;
          w_tx_next     = 1'b0;
          w_ready_next  = 1'b0;
          w_busy_next   = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_next   = ST_DATA;
          w_bit_cnt_next = '0;
          w_tx_next      = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BW'(DATA_W - 1)) begin
            w_bit_cnt_next = '0;
            if (PARITY_EN != 0) begin
              w_state_next = ST_PARITY;
              w_tx_next    = r_parity;
            end else begin
              w_state_next    = ST_STOP;
              w_stop_cnt_next = 1'b0;
              w_tx_next       = 1'b1;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_shift_next   = w_shift_rsh;
            w_tx_next      = w_shift_rsh[0];
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_next    = ST_STOP;
          w_stop_cnt_next = 1'b0;
          w_tx_next       = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            // Ready rises here but cannot accept on this same edge,
            // which guarantees one idle-high cycle between frames.
            w_state_next    = ST_IDLE;
            w_stop_cnt_next = 1'b0;
            w_ready_next    = 1'b1;
            w_busy_next     = 1'b0;
          end else begin
            w_stop_cnt_next = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
        w_ready_next = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers: falling edge, asynchronous preset/clear.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
      r_ready    <= w_ready_next;
      r_busy     <= w_busy_next;
    end
  end

endmodule

// File: tb/tb_ser_tx_negedge.sv
// Scoreboard bench for ser_tx_negedge: three instances cover parity/DIV=4,
// DIV=1 back-to-back framing and two stop bits.
`timescale 1ns/1ps
module tb_ser_tx_negedge;

  typedef struct {
    logic [7:0] data;
    int         gap;
    bit         abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid [3];
  logic [7:0] din   [3];
  logic       tx    [3];
  logic       ready [3];
  logic       busy  [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ser_tx_negedge #(.DATA_W(8), .DIV(4), .PARITY_EN(1), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .data_in(din[0]), .valid_in(valid[0]),
    .ready_out(ready[0]), .tx_out(tx[0]), .busy(busy[0]));
  ser_tx_negedge #(.DATA_W(8), .DIV(1), .PARITY_EN(0), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .data_in(din[1]), .valid_in(valid[1]),
    .ready_out(ready[1]), .tx_out(tx[1]), .busy(busy[1]));
  ser_tx_negedge #(.DATA_W(8), .DIV(2), .PARITY_EN(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .data_in(din[2]), .valid_in(valid[2]),
    .ready_out(ready[2]), .tx_out(tx[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic void push(input int i, input logic [7:0] d, input int gap, input bit ab);
    exp_t e;
    e.data = d; e.gap = gap; e.abort = ab;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop(input int i, output exp_t e);
    e.data = 8'h00; e.gap = 0; e.abort = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // Expected line level per bit period: start 0, data LSB first, parity, stops.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par);
    logic [15:0] v;
    v = '1;
    v[0] = 1'b0;
    v[8:1] = d;
    if (par != 0) v[9] = ^d;
    return v;
  endfunction

  // Monitor: detect a start bit, check every cycle of the frame, then the gap.
  task automatic mon(input int i, input int div, input int par, input int stop);
    int f, cyc, last_start;
    exp_t e;
    bit ok, aborted, have;
    logic [15:0] expv, got;
    f = (1 + 8 + par + stop) * div;
    cyc = 0;
    last_start = -1000;
    forever begin
      @(posedge clk); cyc++;
      if (reset === 1'b0 && tx[i] === 1'b0) begin
        have = pop(i, e);
        if (!have) begin
          total++;
          $display("FAIL unexpected_frame[%0d]: got start bit at cycle %0d, expected idle line", i, cyc);
        end
        if (have && e.gap != 0) chk($sformatf("start_gap[%0d]", i), cyc - last_start, e.gap);
        last_start = cyc;
        expv = frame_bits(e.data, par);
        got = '1;
        ok = 1'b1;
        aborted = 1'b0;
        for (int c = 0; c < f; c++) begin
          if (c > 0) begin @(posedge clk); cyc++; end
          if (reset === 1'b1) begin aborted = 1'b1; break; end
          if (tx[i] !== expv[c / div]) ok = 1'b0;
          if (ready[i] !== 1'b0 || busy[i] !== 1'b1) ok = 1'b0;
          if (c % div == 0) got[c / div] = tx[i];
        end
        if (have) begin
          if (aborted && e.abort) begin
            chk($sformatf("abort_partial[%0d] %h", i, e.data), {31'd0, ok}, 32'd1);
          end else if (aborted != e.abort) begin
            total++;
            $display("FAIL abort_state[%0d] %h: got aborted=%0d expected %0d", i, e.data, aborted, e.abort);
          end else begin
            chk($sformatf("frame_bits[%0d] %h", i, e.data), {15'd0, ok, got}, {15'd0, 1'b1, expv});
            @(posedge clk); cyc++;
            chk($sformatf("frame_end[%0d] rdy/busy/tx", i),
                {29'd0, ready[i], busy[i], tx[i]}, {29'd0, 1'b1, 1'b0, 1'b1});
          end
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0, 4, 1, 1);
      mon(1, 1, 0, 1);
      mon(2, 2, 0, 2);
    join_none
  end

  task automatic wait_ready(input int i);
    int n = 0;
    while (ready[i] !== 1'b1 && n < 300) begin @(posedge clk); n++; end
    if (n >= 300) begin
      total++;
      $display("FAIL ready_timeout[%0d]: got ready low, expected high", i);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d);
    @(posedge clk);
    wait_ready(i);
    push(i, d, 0, 1'b0);
    valid[i] = 1'b1;
    din[i] = d;
    @(posedge clk);
    valid[i] = 1'b0;
    din[i] = ~d;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size() != 0 ||
            ready[0] !== 1'b1 || ready[1] !== 1'b1 || ready[2] !== 1'b1) && n < 2000) begin
      @(posedge clk); n++;
    end
    if (n >= 2000) begin
      total++;
      $display("FAIL drain_timeout: got pending work, expected idle");
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin valid[k] = 1'b0; din[k] = 8'h00; end
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    chk("reset_tx", {31'd0, tx[0]}, 32'd1);
    chk("reset_ready", {31'd0, ready[0]}, 32'd1);
    chk("reset_busy", {31'd0, busy[0]}, 32'd0);
    #1 reset = 1'b0;

    // Single frame with parity.
    send(0, 8'hA5);
    drain();

    // Back-to-back at DIV=1 with valid held.
    @(posedge clk);
    wait_ready(1);
    push(1, 8'h00, 0, 1'b0);
    push(1, 8'hFF, 11, 1'b0);
    valid[1] = 1'b1; din[1] = 8'h00;
    @(posedge clk);
    din[1] = 8'hFF;
    @(posedge clk);
    wait_ready(1);
    @(posedge clk);
    valid[1] = 1'b0; din[1] = 8'h00;
    drain();

    // Stall: valid pulse while busy is ignored.
    send(0, 8'h11);
    repeat (8) @(posedge clk);
    chk("stall_ready", {31'd0, ready[0]}, 32'd0);
    valid[0] = 1'b1; din[0] = 8'h3C;
    @(posedge clk);
    valid[0] = 1'b0; din[0] = 8'h00;
    drain();
    send(0, 8'h3C);
    drain();

    // Data hold: data_in changes to 0xFF right after accept.
    send(0, 8'h00);
    drain();

    // Two stop bits.
    send(2, 8'h01);
    drain();

    // Reset during data bit 3 of 0x5A, then 0x81 with valid held through release.
    @(posedge clk);
    wait_ready(0);
    push(0, 8'h5A, 0, 1'b1);
    valid[0] = 1'b1; din[0] = 8'h5A;
    @(posedge clk);
    valid[0] = 1'b0; din[0] = 8'hA5;
    repeat (17) @(posedge clk);
    chk("busy_before_reset", {31'd0, busy[0]}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midreset_tx", {31'd0, tx[0]}, 32'd1);
    chk("midreset_ready", {31'd0, ready[0]}, 32'd1);
    chk("midreset_busy", {31'd0, busy[0]}, 32'd0);
    push(0, 8'h81, 0, 1'b0);
    valid[0] = 1'b1; din[0] = 8'h81;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    chk("accept_after_release", {30'd0, busy[0], tx[0]}, {30'd0, 1'b1, 1'b0});
    valid[0] = 1'b0; din[0] = 8'h7E;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
